sr_fetch: RTL and testbench
===========================

# sr_fetch

Instruction fetch stage of the schoolRISCV core. It owns the fetch PC, issues word requests to a pipelined instruction memory, and buffers returned words with their PCs in a small queue. The decode/control stage consumes the queue head through a valid/ready handshake. The core top asserts `redirect` whenever the control stage selects a next-PC other than PC+4 (branch, JAL, JALR), so redirects flush the stage and discard stale in-flight responses.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch PC after reset; must be word aligned.
- `QDEPTH`, default 4: instruction queue entries; power of two, ≥2. Also bounds outstanding requests.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  word-aligned fetch address; equals the fetch PC.
- `imem_gnt`  in  1  request accepted this cycle; ignored when `imem_req`=0.
- `imem_rvalid`  in  1  read data valid; responses return in order, latency ≥1 cycle after grant.
- `imem_rdata`  in  32  instruction word.
- `redirect`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new fetch PC.
- `instr_valid`  out  1  queue head valid.
- `instr`  out  32  queue head instruction; 0 when `instr_valid`=0.
- `instr_pc`  out  32  PC of queue head; 0 when `instr_valid`=0.
- `instr_ready`  in  1  consumer accepts head when `instr_valid` is also 1.
- `fetch_misalign`  out  1  sticky: a redirect targeted a non-word-aligned PC.

## Operation
- State: `fetch_pc`, `resp_pc` (PC of next expected response), `inflight` count, `discard` count, queue, misalign flag. Count widths are `$clog2(QDEPTH+1)`. PCs wrap modulo 2^32.
- Issue rule: `imem_req` = !`fetch_misalign` && !`redirect` && (`inflight` + queue count < `QDEPTH`), using registered counts only. There is no combinational path from `instr_ready` to `imem_req`.
- On `imem_req`&&`imem_gnt`: `fetch_pc` += 4 and `inflight` increments.
- Once raised, `imem_req`/`imem_addr` stay stable until grant. The only exception is a redirect cycle, where the request is withdrawn.
- Response handling: on `imem_rvalid`, `inflight` decrements.
  - If `discard`>0, the word is dropped and `discard` decrements.
  - Otherwise {`resp_pc`, `imem_rdata`} is pushed into the queue and `resp_pc` += 4.
- Pop: when `instr_valid`&&`instr_ready`. Push and pop in the same cycle are legal, including when the queue is full.
- Redirect has priority over all other updates in its cycle:
  - A pop in the same cycle counts as accepted; all remaining entries are flushed, along with any response arriving that cycle.
  - `discard` := `inflight` + (grant this cycle? no: request is withdrawn) − (response arriving this cycle ? 1 : 0).
  - `fetch_pc` := `resp_pc` := {`redirect_pc`[31:2], 2'b00}.
  - If `redirect_pc`[1:0] != 0, `fetch_misalign` is set and issue stops until reset. Draining of discards still proceeds.
- A redirect while `discard`>0 accumulates; the new `discard` covers all in-flight requests.
- Protocol violations (flagged by SVA in sim, ignored in RTL): `imem_rvalid` with `inflight`=0; unaligned `RESET_PC`.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0, `instr`=0, `instr_pc`=0, `fetch_misalign`=0. All counters are 0 and the queue is empty.
- First request is raised in the cycle after `rst` deasserts.
- Response-to-output latency: 1 cycle, no bypass. With a 1-cycle memory, grant at cycle N gives `instr_valid` at N+2.
- Redirect at cycle N: queue empty at N+1; `imem_req` with `imem_addr`=`redirect_pc` at N+1.
- Sustained throughput: 1 instr/cycle with 1-cycle memory when `QDEPTH`≥3.
- Reset mid-operation clears everything. Responses to pre-reset requests are illegal; the system must reset memory together with the core.

## Structure
- Add `sr_fetch_entry_t` (packed {pc[31:0], instr[31:0]}) and the `RESET_PC` default constant to the shared core package/header (`sr_cpu.svh`).
- One sub-module, `sr_fetch_queue`: synchronous FIFO of `sr_fetch_entry_t` with push, pop, flush, count, and `QDEPTH` parameter.
- Counters and issue logic live in `sr_fetch`.

## Test plan
- Reset release, `imem_gnt`=1, 1-cycle memory returning `addr`^32'hFFFF_0000, `instr_ready`=1 → `imem_addr` sequence 0,4,8,…; outputs (pc 0, instr 32'hFFFF_0000) at cycle 2, then one per cycle.
- `instr_ready`=0 with 1-cycle memory → exactly 4 grants, then `imem_req`=0 and 4 queued entries at PCs 0,4,8,12; releasing ready drains them in order.
- 3-cycle memory latency, redirect to 32'h100 while 2 requests are in flight → both stale responses dropped; first output is `instr_pc`=32'h100.
- Redirect in the same cycle as a response and a pop → popped entry counted as consumed, response dropped, next `imem_addr`=`redirect_pc`.
- Redirect to 32'h102 → `fetch_misalign`=1 next cycle, `imem_req` stays 0, `instr_valid`=0; `rst` clears the flag and fetch restarts at `RESET_PC`.
- `imem_gnt` held low 5 cycles → `imem_req`/`imem_addr` stable throughout; fetch_pc at 32'hFFFF_FFFC wraps to 0 on the next grant.

Source files
------------

// File: rtl/sr_fetch_pkg.sv
// sr_fetch_pkg: shared fetch-stage types and constants
package sr_fetch_pkg;
  localparam logic [31:0] SR_RESET_PC = 32'h0000_0000;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } sr_fetch_entry_t;
endpackage

// File: rtl/sr_fetch_queue.sv
// sr_fetch_queue: synchronous FIFO of fetched {pc, instr} entries with flush
module sr_fetch_queue
  import sr_fetch_pkg::*;
#(
  parameter int QDEPTH = 4,
  localparam int CW = $clog2(QDEPTH + 1),
  localparam int AW = $clog2(QDEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_flush,
  input  sr_fetch_entry_t i_entry,
  output sr_fetch_entry_t o_head,
  output logic            o_valid,
  output logic [CW-1:0]   o_count
);
  sr_fetch_entry_t r_mem [QDEPTH];
  logic [AW-1:0]   r_rd, r_wr;
  logic [CW-1:0]   r_count;
  logic            w_pop;
  assign w_pop   = i_pop && r_count != '0;
  assign o_head  = r_mem[r_rd];
  assign o_valid = r_count != '0;
  assign o_count = r_count;
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wr] <= i_entry;
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= i_push ? r_wr + 1'b1 : r_wr;
      r_rd    <= w_pop ? r_rd + 1'b1 : r_rd;
      r_count <= r_count + CW'(i_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/sr_fetch.sv
// sr_fetch: schoolRISCV fetch stage - PC, pipelined imem requests, response queue, redirect flush
module sr_fetch
  import sr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = SR_RESET_PC,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fetch_misalign
);
  localparam int CW = $clog2(QDEPTH + 1);
  logic [31:0]     r_fetch_pc, r_resp_pc, w_redir_pc;
  logic [CW-1:0]   r_inflight, r_discard, w_qcount;
  logic [CW:0]     w_occ;
  logic            r_misalign, w_gnt, w_pop, w_push, w_drop, w_qvalid;
  sr_fetch_entry_t w_head, w_entry;
  // occupancy counts both queued words and words still owed by memory
  assign w_occ      = {1'b0, r_inflight} + {1'b0, w_qcount};
  assign imem_req   = !rst && !r_misalign && !redirect && (w_occ < (CW+1)'(QDEPTH));
  assign imem_addr  = r_fetch_pc;
  assign w_gnt      = imem_req && imem_gnt;
  assign w_pop      = w_qvalid && instr_ready;
  assign w_drop     = r_discard != '0;
  assign w_push     = imem_rvalid && !w_drop && !redirect;
  assign w_redir_pc = {redirect_pc[31:2], 2'b00};
  assign w_entry    = '{pc: r_resp_pc, instr: imem_rdata};
  sr_fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .i_entry (w_entry),
    .o_head  (w_head),
    .o_valid (w_qvalid),
    .o_count (w_qcount)
  );
  assign instr_valid    = w_qvalid;
  assign instr          = w_qvalid ? w_head.instr : '0;
  assign instr_pc       = w_qvalid ? w_head.pc : '0;
  assign fetch_misalign = r_misalign;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_inflight <= '0;
      r_discard  <= '0;
      r_misalign <= 1'b0;
    end else if (redirect) begin
      r_fetch_pc <= w_redir_pc;
      r_resp_pc  <= w_redir_pc;
      r_inflight <= r_inflight - CW'(imem_rvalid);
      r_discard  <= r_inflight - CW'(imem_rvalid);
      r_misalign <= r_misalign || redirect_pc[1:0] != 2'b00;
    end else begin
      r_fetch_pc <= w_gnt ? r_fetch_pc + 32'd4 : r_fetch_pc;
      r_resp_pc  <= w_push ? r_resp_pc + 32'd4 : r_resp_pc;
      r_inflight <= r_inflight + CW'(w_gnt) - CW'(imem_rvalid);
      r_discard  <= r_discard - CW'(imem_rvalid && w_drop);
    end
  end
  a_rvalid_owed: assert property (@(posedge clk) disable iff (rst) imem_rvalid |-> r_inflight != '0)
    else $error("imem_rvalid with no request in flight");
  a_reset_pc_aligned: assert property (@(posedge clk) RESET_PC[1:0] == 2'b00)
    else $error("RESET_PC not word aligned");
endmodule

// File: tb/tb_sr_fetch.sv
// tb_sr_fetch: randomized fetch-stage bench against a queue-based reference model
module tb_sr_fetch;
  import sr_fetch_pkg::*;
  localparam int          QD   = 4;
  localparam logic [31:0] RPC  = 32'h0000_0000;
  localparam logic [31:0] MASK = 32'hFFFF_0000;
  logic clk = 1'b0, rst = 1'b1;
  logic imem_req, imem_gnt, imem_rvalid, redirect, instr_valid, instr_ready, fetch_misalign;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;
  always #5 clk = ~clk;
  sr_fetch #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .fetch_misalign(fetch_misalign)
  );
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t       mem_q[$];
  logic [63:0] m_q[$];
  logic [31:0] m_fetch, m_resp, force_rpc, first_pc;
  int          m_infl, m_disc, cyc, grants, first_v;
  bit          m_mis, force_redir;
  int          p_gnt, p_ready, p_redir, lat_lo, lat_hi;
  int          n_vec = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    redirect = 0; redirect_pc = 0; instr_ready = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_misalign", fetch_misalign, 0);
    m_fetch = RPC; m_resp = RPC; m_infl = 0; m_disc = 0; m_mis = 0;
    m_q.delete(); mem_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
  endtask
  task automatic step();
    bit g, rd, rv, pop, mreq;
    logic [31:0] rpc;
    @(negedge clk);
    imem_gnt    = $urandom_range(99) < p_gnt;
    instr_ready = $urandom_range(99) < p_ready;
    rd  = force_redir || ($urandom_range(99) < p_redir);
    rpc = force_redir ? force_rpc : {20'h0, 10'($urandom), 2'b00};
    force_redir = 0;
    redirect = rd; redirect_pc = rpc;
    rv = mem_q.size() > 0 && mem_q[0].due <= cyc;
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_q[0].addr ^ MASK : $urandom;
    if (rv) void'(mem_q.pop_front());
    #1;
    mreq = !m_mis && !rd && (m_infl + m_q.size() < QD);
    chk("req", imem_req, mreq);
    chk("addr", imem_addr, m_fetch);
    chk("valid", instr_valid, m_q.size() > 0);
    chk("instr", instr, m_q.size() > 0 ? m_q[0][31:0] : 32'h0);
    chk("instr_pc", instr_pc, m_q.size() > 0 ? m_q[0][63:32] : 32'h0);
    chk("misalign", fetch_misalign, m_mis);
    if (instr_valid && first_v < 0) begin first_v = cyc; first_pc = instr_pc; end
    if (imem_req && imem_gnt) begin
      mem_q.push_back('{imem_addr, cyc + $urandom_range(lat_hi, lat_lo)});
      grants++;
    end
    g   = mreq && imem_gnt;
    pop = m_q.size() > 0 && instr_ready;
    @(posedge clk);
    cyc++;
    if (rd) begin
      m_q.delete();
      m_disc  = m_infl - int'(rv);
      m_infl -= int'(rv);
      m_fetch = {rpc[31:2], 2'b00};
      m_resp  = m_fetch;
      if (rpc[1:0] != 2'b00) m_mis = 1;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (rv) begin
        m_infl--;
        if (m_disc > 0) m_disc--;
        else begin
          m_q.push_back({m_resp, m_resp ^ MASK});
          m_resp += 4;
        end
      end
      if (g) begin m_fetch += 4; m_infl++; end
    end
  endtask
  initial begin
    force_redir = 0; force_rpc = 0; first_pc = 0;
    p_gnt = 100; p_ready = 100; p_redir = 0; lat_lo = 1; lat_hi = 1;
    do_reset();
    first_v = -1;
    repeat (12) step();
    chk("first_valid_cycle", first_v, 2);
    do_reset();
    p_ready = 0; grants = 0;
    repeat (10) step();
    chk("stall_grants", grants, 4);
    p_ready = 100;
    repeat (8) step();
    do_reset();
    lat_lo = 3; lat_hi = 3; p_ready = 100;
    repeat (2) step();
    first_v = -1; force_redir = 1; force_rpc = 32'h100;
    repeat (12) step();
    chk("redir_first_pc", first_pc, 32'h100);
    do_reset();
    lat_lo = 1; lat_hi = 1;
    repeat (5) step();
    force_redir = 1; force_rpc = 32'h40;
    repeat (6) step();
    force_redir = 1; force_rpc = 32'h102;
    repeat (6) step();
    chk("misalign_sticky", fetch_misalign, 1);
    chk("misalign_noreq", imem_req, 0);
    do_reset();
    repeat (3) step();
    force_redir = 1; force_rpc = 32'hFFFF_FFFC; p_gnt = 0;
    repeat (6) step();
    p_gnt = 100;
    repeat (6) step();
    do_reset();
    p_gnt = 70; p_ready = 60; p_redir = 5; lat_lo = 1; lat_hi = 4;
    repeat (1500) step();
    do_reset();
    repeat (1500) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
